// File: rtl/wt_store_merge_buf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wt_store_merge_buf_pkg
//  Description : Shared types and helpers for the write-through store merge
//                buffer: entry state encoding, entry record, word addressing.
//  Revision    : 1.0 - initial release
// ============================================================================
package wt_store_merge_buf_pkg;

  // Build configuration; the entry record below is sized from these values.
  localparam int unsigned WB_PADDR_W = 34;
  localparam int unsigned WB_DATA_W  = 32;
  localparam int unsigned WB_BE_W    = WB_DATA_W / 8;
  localparam int unsigned WB_TID_W   = 2;
  localparam int unsigned WB_OFF_W   = $clog2(WB_BE_W);

  typedef enum logic [1:0] {
    WB_FREE = 2'd0,
    WB_PEND = 2'd1,
    WB_INFL = 2'd2
  } wbuf_state_e;

  typedef struct packed {
    logic [WB_PADDR_W-1:0] paddr;
    logic [WB_DATA_W-1:0]  data;
    logic [WB_BE_W-1:0]    be;
    logic [WB_TID_W-1:0]   tid;
    wbuf_state_e           state;
  } wbuf_entry_t;

  // Clears the byte-offset bits so two stores to the same word compare equal.
  function automatic logic [WB_PADDR_W-1:0] word_addr(input logic [WB_PADDR_W-1:0] paddr);
    return {paddr[WB_PADDR_W-1:WB_OFF_W], {WB_OFF_W{1'b0}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/wt_store_tid_pool.sv
`default_nettype none
// ============================================================================
//  Module      : wt_store_tid_pool
//  Description : Free-list bitmap of memory transaction IDs. Hands out the
//                lowest free ID; a release becomes visible the next cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module wt_store_tid_pool
  import wt_store_merge_buf_pkg::*;
#(
  parameter int unsigned TID_W = WB_TID_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_i,
  input  logic [TID_W-1:0]      alloc_tid_i,
  input  logic                  rel_i,
  input  logic [TID_W-1:0]      rel_tid_i,
  output logic                  any_free_o,
  output logic [TID_W-1:0]      free_tid_o,
  output logic [(2**TID_W)-1:0] busy_o
);

  localparam int unsigned NTID = 2**TID_W;

  logic [NTID-1:0]  r_busy;
  logic [TID_W-1:0] w_free_tid;

  // Busy bitmap: set on allocation, cleared on release (never both for one ID).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < NTID; i++) begin
        if (alloc_i && alloc_tid_i == TID_W'(i)) begin
          r_busy[i] <= 1'b1;
        end else if (rel_i && rel_tid_i == TID_W'(i)) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  // Lowest-index free ID wins; scan from the top so the last hit is the lowest.
  always_comb begin
    w_free_tid = '0;
    for (int i = NTID - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_tid = TID_W'(i);
      end
    end
  end

  assign any_free_o = ~&r_busy;
  assign free_tid_o = w_free_tid;
  assign busy_o     = r_busy;

endmodule
`default_nettype wire

// File: rtl/wt_store_merge_buf.sv
`default_nettype none
// ============================================================================
//  Module      : wt_store_merge_buf
//  Description : Write-through store merge buffer. Merges byte stores to a
//                word that has not yet been issued, issues entries to memory
//                in allocation order with a transaction ID, frees on ack.
//  Revision    : 1.0 - initial release
// ============================================================================
module wt_store_merge_buf
  import wt_store_merge_buf_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned PADDR_W = WB_PADDR_W,
  parameter int unsigned DATA_W  = WB_DATA_W,
  parameter int unsigned TID_W   = WB_TID_W
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PADDR_W-1:0]    req_paddr_i,
  input  logic [DATA_W-1:0]     req_data_i,
  input  logic [DATA_W/8-1:0]   req_be_i,
  output logic                  mem_valid_o,
  input  logic                  mem_ready_i,
  output logic [PADDR_W-1:0]    mem_paddr_o,
  output logic [DATA_W-1:0]     mem_data_o,
  output logic [DATA_W/8-1:0]   mem_be_o,
  output logic [TID_W-1:0]      mem_tid_o,
  input  logic                  ack_valid_i,
  input  logic [TID_W-1:0]      ack_tid_i,
  input  logic [PADDR_W-1:0]    ld_paddr_i,
  output logic                  ld_hit_o,
  output logic                  empty_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  wbuf_entry_t        r_ent [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_iss_ptr;
  logic               r_hold;
  logic [TID_W-1:0]   r_hold_tid;

  logic [PADDR_W-1:0] w_req_waddr;
  logic [PADDR_W-1:0] w_ld_waddr;
  logic               w_infl_conflict;
  logic               w_mem_valid;
  logic [TID_W-1:0]   w_issue_tid;
  logic               w_mem_hs;
  logic               w_merge_hit;
  logic [PTR_W-1:0]   w_merge_idx;
  logic               w_enq;
  logic               w_ack_hit;
  logic [PTR_W-1:0]   w_ack_idx;
  logic               w_any_free;
  logic [TID_W-1:0]   w_free_tid;
  logic [(2**TID_W)-1:0] w_busy;
  logic               w_ld_hit;
  logic               w_empty;

  assign w_req_waddr = word_addr(req_paddr_i);
  assign w_ld_waddr  = word_addr(ld_paddr_i);

  wt_store_tid_pool #(
    .TID_W (TID_W)
  ) u_tid_pool (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .alloc_i     (w_mem_hs),
    .alloc_tid_i (w_issue_tid),
    .rel_i       (w_ack_hit),
    .rel_tid_i   (ack_tid_i),
    .any_free_o  (w_any_free),
    .free_tid_o  (w_free_tid),
    .busy_o      (w_busy)
  );

  // Issue candidate: head entry pending, an ID available, and no older write
  // to the same word still in flight (keeps same-word writes ordered).
  always_comb begin
    w_infl_conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].state == WB_INFL && r_ent[i].paddr == r_ent[r_iss_ptr].paddr) begin
        w_infl_conflict = 1'b1;
      end
    end
    w_mem_valid = (r_ent[r_iss_ptr].state == WB_PEND) && w_any_free && !w_infl_conflict;
    // Once presented, the ID is frozen so a lower ID freed meanwhile cannot change it.
    w_issue_tid = r_hold ? r_hold_tid : w_free_tid;
    w_mem_hs    = w_mem_valid && mem_ready_i;
  end

  // Merge lookup, ack lookup and status flags over all entries.
  always_comb begin
    w_merge_hit = 1'b0;
    w_merge_idx = '0;
    w_ack_idx   = '0;
    w_ld_hit    = 1'b0;
    w_empty     = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_ent[i].state == WB_PEND && r_ent[i].paddr == w_req_waddr &&
          !(w_mem_valid && r_iss_ptr == PTR_W'(i))) begin
        w_merge_hit = 1'b1;
        w_merge_idx = PTR_W'(i);
      end
      if (r_ent[i].state == WB_INFL && r_ent[i].tid == ack_tid_i) begin
        w_ack_idx = PTR_W'(i);
      end
      if (r_ent[i].state != WB_FREE) begin
        w_empty = 1'b0;
        if (r_ent[i].paddr == w_ld_waddr) begin
          w_ld_hit = 1'b1;
        end
      end
    end
  end

  assign req_ready_o = w_merge_hit || (r_ent[r_wr_ptr].state == WB_FREE);
  assign w_enq       = req_valid_i && req_ready_o;
  assign w_ack_hit   = ack_valid_i && w_busy[ack_tid_i];

  // Entry storage: ack frees, issue moves to in-flight, enqueue merges or allocates.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ent[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_ack_hit && w_ack_idx == PTR_W'(i)) begin
          r_ent[i].state <= WB_FREE;
        end
        if (w_mem_hs && r_iss_ptr == PTR_W'(i)) begin
          r_ent[i].state <= WB_INFL;
          r_ent[i].tid   <= w_issue_tid;
        end
        if (w_enq && w_merge_hit && w_merge_idx == PTR_W'(i)) begin
          r_ent[i].be <= r_ent[i].be | req_be_i;
          for (int b = 0; b < BE_W; b++) begin
            if (req_be_i[b]) begin
              r_ent[i].data[8*b +: 8] <= req_data_i[8*b +: 8];
            end
          end
        end
        if (w_enq && !w_merge_hit && r_wr_ptr == PTR_W'(i)) begin
          r_ent[i] <= '{paddr: w_req_waddr, data: req_data_i, be: req_be_i,
                        tid: '0, state: WB_PEND};
        end
      end
    end
  end

  // Ring pointers and the held-ID register for a stalled presentation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_iss_ptr  <= '0;
      r_hold     <= 1'b0;
      r_hold_tid <= '0;
    end else begin
      if (w_enq && !w_merge_hit) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_mem_hs) begin
        r_iss_ptr <= r_iss_ptr + PTR_W'(1);
      end
      r_hold     <= w_mem_valid && !mem_ready_i;
      r_hold_tid <= w_issue_tid;
    end
  end

  assign mem_valid_o = w_mem_valid;
  assign mem_paddr_o = w_mem_valid ? r_ent[r_iss_ptr].paddr : '0;
  assign mem_data_o  = w_mem_valid ? r_ent[r_iss_ptr].data  : '0;
  assign mem_be_o    = w_mem_valid ? r_ent[r_iss_ptr].be    : '0;
  assign mem_tid_o   = w_mem_valid ? w_issue_tid            : '0;
  assign ld_hit_o    = w_ld_hit;
  assign empty_o     = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_wt_store_merge_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wt_store_merge_buf
//  Description : Self-checking bench for wt_store_merge_buf with a
//                behavioural reference model, directed scenarios and a
//                randomized phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wt_store_merge_buf;

  localparam int DEPTH = 8;
  localparam int NTID  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [33:0] req_paddr;
  logic [31:0] req_data;
  logic [3:0]  req_be;
  logic        mem_valid, mem_ready;
  logic [33:0] mem_paddr;
  logic [31:0] mem_data;
  logic [3:0]  mem_be;
  logic [1:0]  mem_tid;
  logic        ack_valid;
  logic [1:0]  ack_tid;
  logic [33:0] ld_paddr;
  logic        ld_hit, empty;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wt_store_merge_buf dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_paddr_i(req_paddr),
    .req_data_i(req_data), .req_be_i(req_be),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_paddr_o(mem_paddr),
    .mem_data_o(mem_data), .mem_be_o(mem_be), .mem_tid_o(mem_tid),
    .ack_valid_i(ack_valid), .ack_tid_i(ack_tid),
    .ld_paddr_i(ld_paddr), .ld_hit_o(ld_hit), .empty_o(empty)
  );

  // ---------------- reference model (0 free, 1 pending, 2 in flight) -------
  int          m_st   [DEPTH];
  logic [33:0] m_addr [DEPTH];
  logic [31:0] m_data [DEPTH];
  logic [3:0]  m_be   [DEPTH];
  int          m_tid  [DEPTH];
  bit          m_busy [NTID];
  int          m_wr, m_iss, m_held_tid;
  bit          m_held, m_init = 0;

  function automatic logic [33:0] wa(input logic [33:0] a);
    return {a[33:2], 2'b00};
  endfunction

  function automatic int lowest_free();
    for (int t = 0; t < NTID; t++) if (!m_busy[t]) return t;
    return -1;
  endfunction

  function automatic bit exp_mvalid();
    if (m_st[m_iss] != 1) return 0;
    if (lowest_free() < 0) return 0;
    for (int j = 0; j < DEPTH; j++)
      if (m_st[j] == 2 && m_addr[j] == m_addr[m_iss]) return 0;
    return 1;
  endfunction

  function automatic int exp_tid();
    return m_held ? m_held_tid : lowest_free();
  endfunction

  function automatic int merge_idx(input logic [33:0] a);
    for (int j = 0; j < DEPTH; j++)
      if (m_st[j] == 1 && m_addr[j] == wa(a) && !(exp_mvalid() && j == m_iss)) return j;
    return -1;
  endfunction

  function automatic bit exp_ready();
    return (merge_idx(req_paddr) >= 0) || (m_st[m_wr] == 0);
  endfunction

  function automatic bit exp_ldhit();
    for (int j = 0; j < DEPTH; j++) if (m_st[j] != 0 && m_addr[j] == wa(ld_paddr)) return 1;
    return 0;
  endfunction

  function automatic bit exp_empty();
    for (int j = 0; j < DEPTH; j++) if (m_st[j] != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < DEPTH; j++) begin
      m_st[j] = 0; m_addr[j] = '0; m_data[j] = '0; m_be[j] = '0; m_tid[j] = 0;
    end
    for (int t = 0; t < NTID; t++) m_busy[t] = 0;
    m_wr = 0; m_iss = 0; m_held = 0; m_held_tid = 0; m_init = 1;
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit mv;
    int t, mi;
    bit rdy;
    if (rst) begin model_reset(); return; end
    if (!m_init) return;
    mv = exp_mvalid(); t = exp_tid(); mi = merge_idx(req_paddr); rdy = exp_ready();
    if (ack_valid && m_busy[ack_tid]) begin
      for (int j = 0; j < DEPTH; j++)
        if (m_st[j] == 2 && m_tid[j] == int'(ack_tid)) m_st[j] = 0;
      m_busy[ack_tid] = 0;
    end
    if (mv && mem_ready) begin
      m_st[m_iss] = 2; m_tid[m_iss] = t; m_busy[t] = 1;
      m_iss = (m_iss + 1) % DEPTH;
    end
    if (req_valid && rdy) begin
      if (mi >= 0) begin
        for (int b = 0; b < 4; b++) if (req_be[b]) m_data[mi][8*b +: 8] = req_data[8*b +: 8];
        m_be[mi] = m_be[mi] | req_be;
      end else begin
        m_st[m_wr] = 1; m_addr[m_wr] = wa(req_paddr); m_data[m_wr] = req_data;
        m_be[m_wr] = req_be; m_wr = (m_wr + 1) % DEPTH;
      end
    end
    m_held = mv && !mem_ready;
    m_held_tid = t;
  endtask

  // ---------------- checking ----------------------------------------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    bit mv;
    mv = exp_mvalid();
    chk("req_ready", req_ready, exp_ready());
    chk("mem_valid", mem_valid, mv);
    if (mv) begin
      chk("mem_paddr", mem_paddr, m_addr[m_iss]);
      chk("mem_data",  mem_data,  m_data[m_iss]);
      chk("mem_be",    mem_be,    m_be[m_iss]);
      chk("mem_tid",   mem_tid,   exp_tid());
    end
    chk("ld_hit", ld_hit, exp_ldhit());
    chk("empty",  empty,  exp_empty());
  endtask

  // One clock: compare with inputs applied, step model, cross the edge.
  task automatic cycle();
    #3;
    if (m_init) compare_all();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0; ack_valid = 0;
  endtask

  task automatic store(input logic [33:0] a, input logic [31:0] d, input logic [3:0] be);
    req_valid = 1; req_paddr = a; req_data = d; req_be = be;
  endtask

  task automatic drain();
    mem_ready = 1; req_valid = 0;
    for (int k = 0; k < 100; k++) begin
      if (exp_empty()) break;
      ack_valid = 0;
      for (int t = NTID - 1; t >= 0; t--)
        if (m_busy[t]) begin ack_valid = 1; ack_tid = 2'(t); end
      cycle();
    end
    ack_valid = 0;
    #1 chk("drain_empty", empty, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int n_iss;
    logic [3:0] tmask;
    logic [33:0] a;
    rst = 1; req_valid = 0; req_paddr = '0; req_data = '0; req_be = '0;
    mem_ready = 0; ack_valid = 0; ack_tid = '0; ld_paddr = 34'h0_8000_0000;
    @(posedge clk); #1;
    cycle(); cycle();
    rst = 0;

    // Reset state.
    #1;
    chk("rst_ready", req_ready, 1); chk("rst_mvalid", mem_valid, 0);
    chk("rst_paddr", mem_paddr, 0); chk("rst_data", mem_data, 0);
    chk("rst_be", mem_be, 0); chk("rst_tid", mem_tid, 0);
    chk("rst_ldhit", ld_hit, 0); chk("rst_empty", empty, 1);

    // Single store, issue next cycle, ack empties.
    mem_ready = 1;
    store(34'h0_8000_0000, 32'hAABB_CCDD, 4'hF);
    cycle(); idle(); #1;
    chk("s1_mvalid", mem_valid, 1); chk("s1_paddr", mem_paddr, 34'h0_8000_0000);
    chk("s1_tid", mem_tid, 0); chk("s1_data", mem_data, 32'hAABB_CCDD);
    cycle();
    ack_valid = 1; ack_tid = 0; #1 chk("s1_notempty", empty, 0);
    cycle(); idle(); #1 chk("s1_empty", empty, 1);

    // Byte merge behind a stalled head entry.
    mem_ready = 0;
    store(34'h0_8000_0000, 32'h55, 4'hF); cycle();
    store(34'h0_8000_0004, 32'h11, 4'h1); cycle();
    store(34'h0_8000_0005, 32'h2200, 4'h2); #1 chk("mrg_ready", req_ready, 1);
    cycle(); idle(); mem_ready = 1; #1;
    chk("mrg_head", mem_paddr, 34'h0_8000_0000);
    cycle(); #1;
    chk("mrg_valid", mem_valid, 1); chk("mrg_paddr", mem_paddr, 34'h0_8000_0004);
    chk("mrg_be", mem_be, 4'h3); chk("mrg_data", mem_data[15:0], 16'h2211);
    cycle(); #1 chk("mrg_one_write", mem_valid, 0);
    drain();

    // Four in-flight IDs, fifth held until an ack frees tid 2.
    mem_ready = 1; n_iss = 0; tmask = '0;
    for (int k = 0; k < 10; k++) begin
      if (k < 6) store(34'h0_8000_1000 + 34'(4*k), 32'(k), 4'hF); else idle();
      #1;
      if (mem_valid) begin n_iss++; tmask[mem_tid] = 1'b1; end
      cycle();
    end
    chk("ids_issued", n_iss, 4); chk("ids_mask", tmask, 4'hF);
    chk("fifth_held", mem_valid, 0);
    ack_valid = 1; ack_tid = 2; #1 chk("ack_nobypass", mem_valid, 0);
    cycle(); idle(); #1;
    chk("fifth_valid", mem_valid, 1); chk("fifth_tid", mem_tid, 2);
    chk("fifth_paddr", mem_paddr, 34'h0_8000_1010);
    drain();

    // Fill all entries: new word refused, pending word still merges.
    mem_ready = 0;
    for (int k = 0; k < 8; k++) begin
      store(34'h0_A000_0000 + 34'(4*k), 32'h100 + 32'(k), 4'h1); cycle();
    end
    store(34'h0_A000_0100, 32'h0, 4'h1); #1 chk("full_new", req_ready, 0);
    req_paddr = 34'h0_A000_0006; req_data = 32'h00CC_0000; req_be = 4'h4;
    #1 chk("full_merge", req_ready, 1);
    ld_paddr = 34'h0_A000_0009; #1 chk("ld_hit_stored", ld_hit, 1);
    ld_paddr = 34'h0_9000_0000; #1 chk("ld_hit_other", ld_hit, 0);
    cycle(); idle();
    drain();

    // Same word stored again while the first write is in flight.
    mem_ready = 1;
    store(34'h0_B000_0000, 32'h1, 4'hF); cycle(); idle(); cycle();
    store(34'h0_B000_0000, 32'h2, 4'hF); cycle(); idle(); #1;
    chk("raw_blocked", mem_valid, 0);
    ack_valid = 1; ack_tid = 3; cycle(); idle(); #1;
    chk("bogus_ack_mv", mem_valid, 0); chk("bogus_ack_empty", empty, 0);
    ack_valid = 1; ack_tid = 0; cycle(); idle(); #1;
    chk("raw_release", mem_valid, 1); chk("raw_release_data", mem_data, 32'h2);
    drain();

    // Mid-operation reset with three in flight and two pending.
    mem_ready = 1;
    for (int k = 0; k < 4; k++) begin store(34'h0_C000_0000 + 34'(4*k), 32'(k), 4'hF); cycle(); end
    mem_ready = 0;
    store(34'h0_C000_0010, 32'h4, 4'hF); cycle(); idle(); cycle();
    rst = 1; cycle(); rst = 0; #1;
    chk("mrst_empty", empty, 1); chk("mrst_mvalid", mem_valid, 0);
    ack_valid = 1; ack_tid = 0; cycle(); idle(); #1;
    chk("late_ack_empty", empty, 1); chk("late_ack_ready", req_ready, 1);

    // Randomized traffic over a small set of words to force merges and hazards.
    for (int k = 0; k < 3000; k++) begin
      int nb;
      int bl [NTID];
      rst = ($urandom_range(0, 599) == 0);
      req_valid = ($urandom_range(0, 99) < 50);
      a = 34'h0_8000_0000 + 34'(4 * $urandom_range(0, 5)) + 34'($urandom_range(0, 3));
      req_paddr = a; req_data = $urandom(); req_be = 4'($urandom_range(0, 15));
      mem_ready = ($urandom_range(0, 99) < 60);
      ld_paddr = ($urandom_range(0, 3) == 0) ? 34'h0_9000_0000
                 : 34'h0_8000_0000 + 34'(4 * $urandom_range(0, 5));
      nb = 0;
      for (int t = 0; t < NTID; t++) if (m_busy[t]) begin bl[nb] = t; nb++; end
      if (nb > 0 && $urandom_range(0, 99) < 30) begin
        ack_valid = 1; ack_tid = 2'(bl[$urandom_range(0, nb - 1)]);
      end else if ($urandom_range(0, 99) < 5) begin
        ack_valid = 1; ack_tid = 2'($urandom_range(0, 3));
      end else begin
        ack_valid = 0;
      end
      cycle();
    end
    rst = 0; idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
